llr_demapper_frame_ctrl: RTL and testbench
==========================================

# llr_demapper_frame_ctrl

Frame-level sequencer in front of the even-QAM LLR demapper. It accepts one frame descriptor at a time (modulation order, symbol count) and pulls that many complex symbols from an upstream source with a valid/ready handshake. It drives the demapper's `ival`/`isop`/`iqam`/data inputs and throttles issue against a credit counter that mirrors free space in the downstream LLR buffer. It reports frame completion only after the last symbol has left the demapper pipeline.

## Interface

**Parameters**
- `pBMAX`, 12: largest bits-per-symbol the downstream demapper is built for.
- `pDAT_W`, 9: I/Q sample width.
- `pLEN_W`, 12: frame length counter width, in symbols.
- `pDELAY`, 7: demapper latency in ticks, from `odm_val` to the demapper's `oval`.
- `pCREDITS`, 16: downstream buffer depth, in symbols; range 1..255.

**Ports**
- `iclk`  in  1  clock.
- `ireset`  in  1  synchronous active-high reset.
- `iclkena`  in  1  clock enable; all state holds when low.
- `icfg_val`  in  1  frame descriptor valid.
- `icfg_qam`  in  4  bits per symbol; legal values are 1, 2, 4, 6, 8, 10, each also ≤ `pBMAX`.
- `icfg_len`  in  `pLEN_W`  symbols in the frame; 0 is illegal.
- `ocfg_rdy`  out  1  descriptor accepted when high (combinational, `state==IDLE`).
- `isym_val`  in  1  symbol valid.
- `isym_re`, `isym_im`  in  `pDAT_W`, signed  symbol.
- `osym_rdy`  out  1  combinational, `state==RUN && credits!=0`.
- `odm_val`, `odm_sop`  out  1  registered demapper `ival`/`isop`.
- `odm_qam`  out  4  registered demapper `iqam`.
- `odm_re`, `odm_im`  out  `pDAT_W`, signed  registered demapper data.
- `icredit_ret`  in  1  downstream freed one symbol slot (one pulse per symbol).
- `obusy`  out  1  frame in progress, including drain.
- `oeop`  out  1  one-tick pulse together with the last `odm_val` of the frame.
- `odone`  out  1  one-tick pulse when the drain ends.
- `oerr`  out  1  one-tick pulse on an illegal descriptor.
- `ocredit_err`  out  1  one-tick pulse on a credit return while the counter is already at `pCREDITS`.

## Operation

**Qualifiers**
- All state updates are qualified by `iclkena`.
- A descriptor transfer is `icfg_val & ocfg_rdy & iclkena`.
- A symbol transfer is `isym_val & osym_rdy & iclkena`.

**FSM states: IDLE, RUN, DRAIN**
- IDLE
  - On a descriptor transfer, latch `qam` and set `cnt = icfg_len-1`.
  - If `qam` is illegal or `len==0`: pulse `oerr` and stay in IDLE.
  - Otherwise go to RUN and set `first=1`.
- RUN
  - Each symbol transfer produces, next tick: `odm_val=1`, `odm_sop=first`, `odm_qam=qam`, and the data.
  - Each symbol transfer clears `first`.
  - If `cnt==0`: `oeop=1` and the state goes to DRAIN with `dcnt=pDELAY-1`.
  - Otherwise `cnt` decrements.
- DRAIN
  - `dcnt` decrements each enabled tick.
  - At `dcnt==0`: pulse `odone` and go to IDLE.
- Without a transfer, `odm_val`, `odm_sop` and `oeop` are 0 next enabled tick.
- `odm_qam`, `odm_re` and `odm_im` hold their last value.

**Credit counter** (width `$clog2(pCREDITS+1)`)
- Persists across frames.
- Each symbol issue takes −1; each `icredit_ret` gives +1.
- An issue and a return in the same tick leave the counter unchanged.
- A return while the counter is at `pCREDITS` with no issue that tick: the counter saturates and `ocredit_err` pulses.
- The counter never underflows: issue requires `credits!=0`.

**`obusy`**: high when `state!=IDLE`.

## Timing

**Reset values**
- State IDLE, `credits=pCREDITS`.
- `odm_val=0`, `odm_sop=0`, `odm_qam=0`, `odm_re=0`, `odm_im=0`.
- `oeop=0`, `odone=0`, `oerr=0`, `ocredit_err=0`, `obusy=0`.

**Latency**
- Descriptor transfer at tick T gives RUN at T+1, so `osym_rdy` can first be high at T+1.
- Symbol transfer at tick T gives `odm_*` at T+1.
- Demapper output follows at T+1+`pDELAY`.
- For the last symbol transferred at T: DRAIN covers T+1..T+`pDELAY`, `odone` pulses at T+`pDELAY`, and `ocfg_rdy` rises at T+`pDELAY`+1.
- Back-to-back frames therefore have a gap of `pDELAY`+1 ticks.

**Throughput**: one symbol per tick while credits remain.

**Boundary conditions**
- A `len==1` frame gives `odm_sop` and `oeop` in the same tick.
- Credits reaching 0 drop `osym_rdy` combinationally in the same tick the counter reads 0.
- A credit return at 0 credits re-enables issue on the next tick.
- `iclkena` low mid-frame: no transfers occur, all outputs hold, and pulses are not repeated or lost (they are emitted on the enabled tick).
- `ireset` mid-frame: immediate return to the reset values, and the in-flight frame is abandoned.

## Test plan

- **Nominal 16-QAM frame**: qam=4, len=3, `isym_val` held high, credits=16.
  - `ocfg_rdy` falls at T+1.
  - `odm_val` is high at T+2..T+4.
  - `odm_sop` is high at T+2 only; `oeop` is high at T+4.
  - `odone` pulses at T+10, `obusy` falls at T+11, and credits end at 13.
- **Credit stall**: `pCREDITS=4`, qam=2, len=6, no returns.
  - 4 symbols are issued, then `osym_rdy`=0.
  - Pulsing `icredit_ret` twice issues the remaining 2; the final credits are 0.
- **Illegal descriptors**: qam=3, qam=12 with `pBMAX`=10, and len=0.
  - Each gives one `oerr` pulse; the state stays IDLE and `odm_val` never rises.
- **Simultaneous issue and return** at credits=1.
  - The counter stays at 1 and issue continues every tick.
  - A return at credits=16 with no issue pulses `ocredit_err`; credits stay 16.
- **Clock-enable gating**: `iclkena` toggled 1/0 during a len=4 frame.
  - Exactly 4 `odm_val` ticks occur, all on enabled cycles.
  - The drain is counted in enabled ticks only.
- **Reset mid-frame**: `ireset` after the second symbol of a len=8 frame.
  - Next tick: all outputs are at their reset values and `ocfg_rdy`=1.
  - A new len=2 frame then runs with `odm_sop` on its first symbol.

Source files
------------

// File: rtl/llr_demapper_frame_ctrl_if.sv
// Descriptor and symbol handshakes into the LLR demapper frame sequencer.
// The master drives descriptors and symbols; the slave returns the ready signals.
interface llr_demapper_frame_ctrl_if #(
   parameter int pLEN_W = 12,
   parameter int pDAT_W = 9
);
   logic                     icfg_val;
   logic [3:0]               icfg_qam;
   logic [pLEN_W-1:0]        icfg_len;
   logic                     ocfg_rdy;
   logic                     isym_val;
   logic signed [pDAT_W-1:0] isym_re;
   logic signed [pDAT_W-1:0] isym_im;
   logic                     osym_rdy;

   modport master (
      output icfg_val, icfg_qam, icfg_len,
      output isym_val, isym_re, isym_im,
      input  ocfg_rdy, osym_rdy
   );

   modport slave (
      input  icfg_val, icfg_qam, icfg_len,
      input  isym_val, isym_re, isym_im,
      output ocfg_rdy, osym_rdy
   );
endinterface

// File: rtl/llr_demapper_frame_ctrl.sv
// Frame sequencer for the even-QAM LLR demapper: pulls one frame of symbols,
// throttled by downstream buffer credits, and signals done after pipeline drain.
module llr_demapper_frame_ctrl #(
   parameter int pBMAX    = 12,
   parameter int pDAT_W   = 9,
   parameter int pLEN_W   = 12,
   parameter int pDELAY   = 7,
   parameter int pCREDITS = 16
) (
   input  logic                     iclk,
   input  logic                     ireset,
   input  logic                     iclkena,
   llr_demapper_frame_ctrl_if.slave bus,
   output logic                     odm_val,
   output logic                     odm_sop,
   output logic [3:0]               odm_qam,
   output logic signed [pDAT_W-1:0] odm_re,
   output logic signed [pDAT_W-1:0] odm_im,
   input  logic                     icredit_ret,
   output logic                     obusy,
   output logic                     oeop,
   output logic                     odone,
   output logic                     oerr,
   output logic                     ocredit_err
);

   localparam int CW = $clog2(pCREDITS + 1);
   localparam int DW = (pDELAY > 1) ? $clog2(pDELAY) : 1;
   localparam logic [CW-1:0] CMAX  = CW'(pCREDITS);
   localparam logic [DW-1:0] DINIT = DW'(pDELAY - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic [pLEN_W-1:0]        cnt_q, cnt_d;
   logic [DW-1:0]            dcnt_q, dcnt_d;
   logic [3:0]               qam_q, qam_d;
   logic                     first_q, first_d;
   logic [CW-1:0]            credits_q, credits_d;
   logic                     val_q, val_d;
   logic                     sop_q, sop_d;
   logic                     eop_q, eop_d;
   logic                     done_q, done_d;
   logic                     err_q, err_d;
   logic                     cerr_q, cerr_d;
   logic [3:0]               dqam_q, dqam_d;
   logic signed [pDAT_W-1:0] re_q, re_d;
   logic signed [pDAT_W-1:0] im_q, im_d;

   logic qam_ok;
   logic sym_xfer;

   assign bus.ocfg_rdy = (state_q == IDLE);
   assign bus.osym_rdy = (state_q == RUN) && (credits_q != '0);
   assign sym_xfer     = bus.isym_val & bus.osym_rdy;

   // Only the even-QAM orders plus BPSK, and none wider than the demapper.
   always_comb begin
      qam_ok = 1'b0;
      case (bus.icfg_qam)
         4'd1, 4'd2, 4'd4, 4'd6, 4'd8, 4'd10: qam_ok = 1'b1;
         default:                             qam_ok = 1'b0;
      endcase
      if (32'(bus.icfg_qam) > 32'(pBMAX))
         qam_ok = 1'b0;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dcnt_d  = dcnt_q;
      qam_d   = qam_q;
      first_d = first_q;
      val_d   = 1'b0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      dqam_d  = dqam_q;
      re_d    = re_q;
      im_d    = im_q;
      unique case (state_q)
         IDLE: begin
            if (bus.icfg_val) begin
               qam_d = bus.icfg_qam;
               cnt_d = bus.icfg_len - 1'b1;
               if (!qam_ok || bus.icfg_len == '0) begin
                  err_d = 1'b1;
               end else begin
                  state_d = RUN;
                  first_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (sym_xfer) begin
               val_d   = 1'b1;
               sop_d   = first_q;
               dqam_d  = qam_q;
               re_d    = bus.isym_re;
               im_d    = bus.isym_im;
               first_d = 1'b0;
               if (cnt_q == '0) begin
                  eop_d   = 1'b1;
                  state_d = DRAIN;
                  dcnt_d  = DINIT;
                  if (pDELAY == 1)
                     done_d = 1'b1;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         DRAIN: begin
            dcnt_d = dcnt_q - 1'b1;
            // Registered pulse lands on the last drain tick.
            if (dcnt_q == DW'(1))
               done_d = 1'b1;
            if (dcnt_q == '0)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      credits_d = credits_q;
      cerr_d    = 1'b0;
      unique case ({sym_xfer, icredit_ret})
         2'b10: credits_d = credits_q - 1'b1;
         2'b01: begin
            if (credits_q == CMAX)
               cerr_d = 1'b1;
            else
               credits_d = credits_q + 1'b1;
         end
         default: credits_d = credits_q;
      endcase
   end

   always_ff @(posedge iclk) begin
      if (ireset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         dcnt_q    <= '0;
         qam_q     <= '0;
         first_q   <= 1'b0;
         credits_q <= CMAX;
         val_q     <= 1'b0;
         sop_q     <= 1'b0;
         eop_q     <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         cerr_q    <= 1'b0;
         dqam_q    <= '0;
         re_q      <= '0;
         im_q      <= '0;
      end else if (iclkena) begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dcnt_q    <= dcnt_d;
         qam_q     <= qam_d;
         first_q   <= first_d;
         credits_q <= credits_d;
         val_q     <= val_d;
         sop_q     <= sop_d;
         eop_q     <= eop_d;
         done_q    <= done_d;
         err_q     <= err_d;
         cerr_q    <= cerr_d;
         dqam_q    <= dqam_d;
         re_q      <= re_d;
         im_q      <= im_d;
      end
   end

   assign odm_val     = val_q;
   assign odm_sop     = sop_q;
   assign odm_qam     = dqam_q;
   assign odm_re      = re_q;
   assign odm_im      = im_q;
   assign oeop        = eop_q;
   assign odone       = done_q;
   assign oerr        = err_q;
   assign ocredit_err = cerr_q;
   assign obusy       = (state_q != IDLE);

endmodule

// File: tb/tb_llr_demapper_frame_ctrl.sv
// Directed bench for llr_demapper_frame_ctrl with a 4-slot downstream buffer,
// a demapper built for up to 10 bits/symbol and a 7-tick pipeline.
module tb_llr_demapper_frame_ctrl;

   logic clk;
   logic rst;
   logic ena;
   logic cr;
   logic odm_val, odm_sop, oeop, odone, oerr, ocredit_err, obusy;
   logic [3:0] odm_qam;
   logic signed [8:0] odm_re, odm_im;

   int n_chk;
   int n_err;

   llr_demapper_frame_ctrl_if #(.pLEN_W(12), .pDAT_W(9)) bus ();

   llr_demapper_frame_ctrl #(
      .pBMAX(10), .pDAT_W(9), .pLEN_W(12), .pDELAY(7), .pCREDITS(4)
   ) dut (
      .iclk(clk), .ireset(rst), .iclkena(ena),
      .bus(bus),
      .odm_val(odm_val), .odm_sop(odm_sop), .odm_qam(odm_qam),
      .odm_re(odm_re), .odm_im(odm_im),
      .icredit_ret(cr),
      .obusy(obusy), .oeop(oeop), .odone(odone),
      .oerr(oerr), .ocredit_err(ocredit_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 40; i++) begin
         if (!obusy) break;
         step();
      end
      chk("drain_end", 32'(obusy), 0);
   endtask

   task automatic give_credits(input int n);
      cr = 1'b1;
      repeat (n) step();
      cr = 1'b0;
   endtask

   task automatic cfg(input logic [3:0] q, input logic [11:0] l);
      bus.icfg_val = 1'b1;
      bus.icfg_qam = q;
      bus.icfg_len = l;
      step();
      bus.icfg_val = 1'b0;
   endtask

   logic [3:0]  bad_q [3];
   logic [11:0] bad_l [3];
   logic        en_now;
   logic [4:0]  snap;
   int en_cnt, v_cnt, s_cnt, e_cnt, d_cnt, hold_bad;

   initial begin
      n_chk = 0;
      n_err = 0;
      rst = 1'b1;
      ena = 1'b1;
      cr  = 1'b0;
      bus.icfg_val = 1'b0;
      bus.icfg_qam = '0;
      bus.icfg_len = '0;
      bus.isym_val = 1'b0;
      bus.isym_re  = '0;
      bus.isym_im  = '0;
      step();
      step();

      // reset values
      chk("rst_cfg_rdy", 32'(bus.ocfg_rdy), 1);
      chk("rst_sym_rdy", 32'(bus.osym_rdy), 0);
      chk("rst_val", 32'(odm_val), 0);
      chk("rst_qam", 32'(odm_qam), 0);
      chk("rst_re", 32'(odm_re), 0);
      chk("rst_busy", 32'(obusy), 0);
      chk("rst_credits", 32'(dut.credits_q), 4);
      rst = 1'b0;
      step();

      // nominal 16-QAM, len 3
      bus.isym_val = 1'b1;
      bus.isym_re = 9'sd11;
      bus.isym_im = -9'sd11;
      chk("nom_cfg_rdy0", 32'(bus.ocfg_rdy), 1);
      cfg(4'd4, 12'd3);
      chk("nom_cfg_rdy1", 32'(bus.ocfg_rdy), 0);
      chk("nom_busy1", 32'(obusy), 1);
      chk("nom_sym_rdy1", 32'(bus.osym_rdy), 1);
      chk("nom_val1", 32'(odm_val), 0);
      step();
      chk("nom_val2", 32'(odm_val), 1);
      chk("nom_sop2", 32'(odm_sop), 1);
      chk("nom_qam2", 32'(odm_qam), 4);
      chk("nom_re2", 32'(odm_re), 32'(-11 + 22));
      chk("nom_im2", 32'(odm_im), 32'(-11));
      chk("nom_eop2", 32'(oeop), 0);
      chk("nom_cred2", 32'(dut.credits_q), 3);
      bus.isym_re = 9'sd22;
      bus.isym_im = -9'sd22;
      step();
      chk("nom_val3", 32'(odm_val), 1);
      chk("nom_sop3", 32'(odm_sop), 0);
      chk("nom_re3", 32'(odm_re), 22);
      chk("nom_eop3", 32'(oeop), 0);
      bus.isym_re = 9'sd33;
      bus.isym_im = -9'sd33;
      step();
      chk("nom_val4", 32'(odm_val), 1);
      chk("nom_eop4", 32'(oeop), 1);
      chk("nom_im4", 32'(odm_im), 32'(-33));
      chk("nom_sym_rdy4", 32'(bus.osym_rdy), 0);
      chk("nom_cred4", 32'(dut.credits_q), 1);
      bus.isym_val = 1'b0;
      step();
      chk("nom_val5", 32'(odm_val), 0);
      chk("nom_eop5", 32'(oeop), 0);
      chk("nom_busy5", 32'(obusy), 1);
      repeat (4) step();
      chk("nom_done9", 32'(odone), 0);
      step();
      chk("nom_done10", 32'(odone), 1);
      chk("nom_busy10", 32'(obusy), 1);
      step();
      chk("nom_done11", 32'(odone), 0);
      chk("nom_busy11", 32'(obusy), 0);
      chk("nom_cfg_rdy11", 32'(bus.ocfg_rdy), 1);
      chk("nom_re_hold", 32'(odm_re), 33);

      // refill, then one return while already full
      cr = 1'b1;
      repeat (3) step();
      chk("ret_full", 32'(dut.credits_q), 4);
      step();
      chk("cerr_pulse", 32'(ocredit_err), 1);
      chk("cerr_cred", 32'(dut.credits_q), 4);
      cr = 1'b0;
      step();
      chk("cerr_clear", 32'(ocredit_err), 0);

      // credit stall: len 6 with 4 credits
      bus.isym_val = 1'b1;
      bus.isym_re = 9'sd1;
      bus.isym_im = 9'sd2;
      cfg(4'd2, 12'd6);
      repeat (4) step();
      chk("stall_val4", 32'(odm_val), 1);
      chk("stall_rdy0", 32'(bus.osym_rdy), 0);
      chk("stall_cred0", 32'(dut.credits_q), 0);
      step();
      chk("stall_val_gap", 32'(odm_val), 0);
      chk("stall_busy", 32'(obusy), 1);
      cr = 1'b1;
      step();
      cr = 1'b0;
      chk("stall_ret_rdy", 32'(bus.osym_rdy), 1);
      chk("stall_ret_cred", 32'(dut.credits_q), 1);
      step();
      chk("stall_val5", 32'(odm_val), 1);
      chk("stall_eop5", 32'(oeop), 0);
      chk("stall_cred5", 32'(dut.credits_q), 0);
      cr = 1'b1;
      step();
      cr = 1'b0;
      chk("stall_val_gap2", 32'(odm_val), 0);
      step();
      chk("stall_val6", 32'(odm_val), 1);
      chk("stall_eop6", 32'(oeop), 1);
      bus.isym_val = 1'b0;
      wait_idle();
      chk("stall_final_cred", 32'(dut.credits_q), 0);
      give_credits(4);
      chk("stall_refill", 32'(dut.credits_q), 4);

      // illegal descriptors
      bad_q[0] = 4'd3;  bad_l[0] = 12'd5;
      bad_q[1] = 4'd12; bad_l[1] = 12'd5;
      bad_q[2] = 4'd4;  bad_l[2] = 12'd0;
      for (int k = 0; k < 3; k++) begin
         cfg(bad_q[k], bad_l[k]);
         chk($sformatf("ill%0d_err", k), 32'(oerr), 1);
         chk($sformatf("ill%0d_busy", k), 32'(obusy), 0);
         chk($sformatf("ill%0d_rdy", k), 32'(bus.ocfg_rdy), 1);
         chk($sformatf("ill%0d_val", k), 32'(odm_val), 0);
         step();
         chk($sformatf("ill%0d_err_clr", k), 32'(oerr), 0);
      end

      // simultaneous issue and return at one credit
      bus.isym_val = 1'b1;
      cfg(4'd6, 12'd6);
      repeat (3) step();
      chk("sim_cred1", 32'(dut.credits_q), 1);
      cr = 1'b1;
      step();
      chk("sim_a_cred", 32'(dut.credits_q), 1);
      chk("sim_a_val", 32'(odm_val), 1);
      chk("sim_a_rdy", 32'(bus.osym_rdy), 1);
      step();
      chk("sim_b_cred", 32'(dut.credits_q), 1);
      chk("sim_b_val", 32'(odm_val), 1);
      step();
      chk("sim_c_cred", 32'(dut.credits_q), 1);
      chk("sim_c_eop", 32'(oeop), 1);
      cr = 1'b0;
      bus.isym_val = 1'b0;
      wait_idle();
      give_credits(3);
      chk("sim_refill", 32'(dut.credits_q), 4);

      // clock-enable gating over a len 4 frame
      bus.isym_val = 1'b1;
      cfg(4'd8, 12'd4);
      en_cnt = 0; v_cnt = 0; s_cnt = 0; e_cnt = 0; d_cnt = 0; hold_bad = 0;
      for (int i = 0; i < 100; i++) begin
         ena = (i % 2 == 0);
         en_now = ena;
         snap = {odm_val, odm_sop, oeop, odone, obusy};
         step();
         if (en_now) begin
            en_cnt++;
            if (odm_val) v_cnt++;
            if (odm_sop) s_cnt++;
            if (oeop) e_cnt++;
            if (odone) d_cnt++;
         end else if ({odm_val, odm_sop, oeop, odone, obusy} !== snap) begin
            hold_bad++;
         end
         if (!obusy) break;
      end
      ena = 1'b1;
      bus.isym_val = 1'b0;
      chk("ce_idle", 32'(obusy), 0);
      chk("ce_val_cnt", 32'(v_cnt), 4);
      chk("ce_sop_cnt", 32'(s_cnt), 1);
      chk("ce_eop_cnt", 32'(e_cnt), 1);
      chk("ce_done_cnt", 32'(d_cnt), 1);
      chk("ce_en_ticks", 32'(en_cnt), 11);
      chk("ce_hold", 32'(hold_bad), 0);
      give_credits(4);
      chk("ce_refill", 32'(dut.credits_q), 4);

      // reset mid-frame, then a fresh len 2 frame
      bus.isym_val = 1'b1;
      bus.isym_re = 9'sd5;
      bus.isym_im = -9'sd5;
      cfg(4'd2, 12'd8);
      step();
      step();
      chk("mr_val_pre", 32'(odm_val), 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mr_val", 32'(odm_val), 0);
      chk("mr_sop", 32'(odm_sop), 0);
      chk("mr_qam", 32'(odm_qam), 0);
      chk("mr_re", 32'(odm_re), 0);
      chk("mr_im", 32'(odm_im), 0);
      chk("mr_eop", 32'(oeop), 0);
      chk("mr_flags", 32'({odone, oerr, ocredit_err}), 0);
      chk("mr_busy", 32'(obusy), 0);
      chk("mr_cfg_rdy", 32'(bus.ocfg_rdy), 1);
      chk("mr_cred", 32'(dut.credits_q), 4);
      bus.isym_re = 9'sd7;
      bus.isym_im = -9'sd7;
      cfg(4'd4, 12'd2);
      step();
      chk("mr2_val1", 32'(odm_val), 1);
      chk("mr2_sop1", 32'(odm_sop), 1);
      chk("mr2_eop1", 32'(oeop), 0);
      chk("mr2_re1", 32'(odm_re), 7);
      bus.isym_re = 9'sd8;
      step();
      chk("mr2_sop2", 32'(odm_sop), 0);
      chk("mr2_eop2", 32'(oeop), 1);
      chk("mr2_re2", 32'(odm_re), 8);
      bus.isym_val = 1'b0;
      wait_idle();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
